// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side arbitration logic.
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [0:0] {
        IDLE,
        BUSY
    } arb_state_t;

    localparam int unsigned MSG_CNT_W = 16;

    // Round-robin candidate: index 'offset' places above 'base', wrapping at n.
    function automatic int unsigned rr_next(input int unsigned base,
                                            input int unsigned offset,
                                            input int unsigned n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request above i_last_grant, wrapping.
// Non-power-of-two request counts wrap at NUM_REQ, so unused indices are never chosen.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_found
);

    // Scan from last_grant+1 upward; lowest offset with a request wins.
    always_comb begin
        int unsigned w_cand;
        o_winner = '0;
        o_found  = 1'b0;
        w_cand   = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = rr_next(32'(i_last_grant), k, NUM_REQ);
            if (!o_found && i_req[w_cand]) begin
                o_found  = 1'b1;
                o_winner = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter in front of the UART transmit byte port.
// A grantee keeps the transmitter until it hands over a byte flagged last.
// Optional macro UART_TX_ARB_TIMEOUT_EN adds a forced release after IDLE_TIMEOUT
// idle cycles and the abort_count port.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_data_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_data_ready,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic [MSG_CNT_W-1:0]       msg_count
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic [7:0]                 abort_count
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || IDLE_TIMEOUT < 2) begin : g_bad_param
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and IDLE_TIMEOUT at least 2");
    end

    arb_state_t             r_state;
    logic [IDX_W-1:0]       r_grant_idx;
    logic [IDX_W-1:0]       r_last_grant;
    logic [MSG_CNT_W-1:0]   r_msg_count;
    logic                   r_busy;

    logic [IDX_W-1:0]       w_winner;
    logic                   w_found;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    byte_t                  w_sel_data;
    logic                   w_xfer;
    logic                   w_timeout;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_found      (w_found)
    );

    // Select the current grantee's valid/last/data.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant_idx == IDX_W'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[i*8 +: 8];
            end
        end
    end

    // Drive the UART side and the grantee's ready; everything is quiet outside BUSY.
    always_comb begin
        tx_data_valid = 1'b0;
        tx_data       = '0;
        req_ready     = '0;
        if (r_state == BUSY) begin
            tx_data_valid = w_sel_valid;
            tx_data       = w_sel_data;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (r_grant_idx == IDX_W'(i)) && tx_data_ready;
            end
        end
    end

    assign w_xfer = (r_state == BUSY) && w_sel_valid && tx_data_ready;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(IDLE_TIMEOUT);

    logic [TO_W-1:0] r_idle_cnt;
    logic [7:0]      r_abort_count;

    // Valid-high-but-stalled cycles neither count nor clear the idle counter.
    assign w_timeout = (r_state == BUSY) && !w_sel_valid &&
                       (r_idle_cnt == TO_W'(IDLE_TIMEOUT - 1));

    // Idle counter and saturating abort counter for forced releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt    <= '0;
            r_abort_count <= '0;
        end else begin
            if (r_state != BUSY || w_xfer || w_timeout) begin
                r_idle_cnt <= '0;
            end else if (!w_sel_valid) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            if (w_timeout && r_abort_count != 8'hFF) begin
                r_abort_count <= r_abort_count + 1'b1;
            end
        end
    end

    assign abort_count = r_abort_count;
`else
    assign w_timeout = 1'b0;
`endif

    // Arbitration FSM: IDLE spends one cycle picking a winner, BUSY holds it to last.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_grant_idx  <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_msg_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant_idx <= w_winner;
                        r_busy      <= 1'b1;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_xfer && w_sel_last) begin
                        r_last_grant <= r_grant_idx;
                        r_msg_count  <= r_msg_count + 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end else if (w_timeout) begin
                        r_last_grant <= r_grant_idx;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign grant_idx = r_grant_idx;
    assign msg_count = r_msg_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model. Builds with or without
// UART_TX_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*8-1:0]  req_data;
    logic            tx_data_valid, tx_data_ready, busy;
    logic [7:0]      tx_data;
    logic [1:0]      grant_idx;
    logic [15:0]     msg_count;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [7:0]      abort_count;
    logic [7:0]      abort3;
`endif

    // Three-requester instance for the non-power-of-two wrap.
    logic [2:0]      rv3, rl3, rr3;
    logic [23:0]     rd3;
    logic            tv3, rdy3, busy3;
    logic [7:0]      td3;
    logic [1:0]      gi3;
    logic [15:0]     mc3;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state.
    bit          m_busy;
    int          m_gnt, m_last, m_idle;
    logic [15:0] m_msg;
    logic [7:0]  m_abort;

    uart_tx_arbiter #(.NUM_REQ(N), .IDLE_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_data_valid(tx_data_valid),
        .tx_data(tx_data), .tx_data_ready(tx_data_ready), .busy(busy),
        .grant_idx(grant_idx), .msg_count(msg_count)
`ifdef UART_TX_ARB_TIMEOUT_EN
        , .abort_count(abort_count)
`endif
    );

    uart_tx_arbiter #(.NUM_REQ(3), .IDLE_TIMEOUT(TO)) dut3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_data(rd3),
        .req_last(rl3), .req_ready(rr3), .tx_data_valid(tv3),
        .tx_data(td3), .tx_data_ready(rdy3), .busy(busy3),
        .grant_idx(gi3), .msg_count(mc3)
`ifdef UART_TX_ARB_TIMEOUT_EN
        , .abort_count(abort3)
`endif
    );

    // Spec-level model: who owns the transmitter, who was served last, message tally.
    function automatic void model_update();
        if (rst) begin
            m_busy = 0; m_gnt = 0; m_last = N - 1; m_msg = 0; m_abort = 0; m_idle = 0;
        end else if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                if (!m_busy && req_valid[(m_last + k) % N]) begin
                    m_gnt = (m_last + k) % N; m_busy = 1; m_idle = 0;
                end
            end
        end else if (req_valid[m_gnt] && tx_data_ready) begin
            m_idle = 0;
            if (req_last[m_gnt]) begin
                m_last = m_gnt; m_msg = m_msg + 16'd1; m_busy = 0;
            end
        end else if (!req_valid[m_gnt]) begin
`ifdef UART_TX_ARB_TIMEOUT_EN
            m_idle++;
            if (m_idle == TO) begin
                m_last = m_gnt; m_busy = 0; m_idle = 0;
                if (m_abort != 8'hFF) m_abort = m_abort + 8'd1;
            end
`endif
        end
    endfunction

    task automatic clk_step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        req_valid = '0; req_last = '0; req_data = '0; tx_data_ready = 1'b0;
        rv3 = '0; rl3 = '0; rd3 = '0; rdy3 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        zero_inputs();
        clk_step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        zero_inputs();
        clk_step();
        clk_step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0h want 0", busy); else n_pass++;
        n_checks++; if (grant_idx !== 2'd0) $display("FAIL reset_grant: got %0d want 0", grant_idx); else n_pass++;
        n_checks++; if (msg_count !== 16'd0) $display("FAIL reset_msg: got %0d want 0", msg_count); else n_pass++;
        n_checks++; if (tx_data_valid !== 1'b0 || tx_data !== 8'h00)
            $display("FAIL reset_tx: got v=%0h d=%0h want v=0 d=0", tx_data_valid, tx_data); else n_pass++;
        n_checks++; if (req_ready !== 4'b0) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
`ifdef UART_TX_ARB_TIMEOUT_EN
        n_checks++; if (abort_count !== 8'd0) $display("FAIL reset_abort: got %0d want 0", abort_count); else n_pass++;
`endif
    endtask

    task automatic test_single_msg();
        do_reset();
        req_valid = 4'b0001; req_data[7:0] = 8'h41; req_last = 4'b0000; tx_data_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || tx_data_valid !== 1'b0)
            $display("FAIL single_idle_cycle: got busy=%0h v=%0h want 0 0", busy, tx_data_valid); else n_pass++;
        clk_step();
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || grant_idx !== 2'd0)
            $display("FAIL single_grant: got busy=%0h g=%0d want 1 0", busy, grant_idx); else n_pass++;
        n_checks++; if (tx_data_valid !== 1'b1 || tx_data !== 8'h41)
            $display("FAIL single_byte0: got v=%0h d=%0h want 1 41", tx_data_valid, tx_data); else n_pass++;
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready); else n_pass++;
        clk_step();
        req_data[7:0] = 8'h42; req_last = 4'b0001;
        @(negedge clk);
        n_checks++; if (tx_data_valid !== 1'b1 || tx_data !== 8'h42 || busy !== 1'b1)
            $display("FAIL single_byte1: got v=%0h d=%0h b=%0h want 1 42 1", tx_data_valid, tx_data, busy); else n_pass++;
        clk_step();
        req_valid = '0; req_last = '0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || msg_count !== 16'd1 || grant_idx !== 2'd0)
            $display("FAIL single_done: got b=%0h m=%0d g=%0d want 0 1 0", busy, msg_count, grant_idx); else n_pass++;
        n_checks++; if (tx_data_valid !== 1'b0 || tx_data !== 8'h00)
            $display("FAIL single_quiet: got v=%0h d=%0h want 0 0", tx_data_valid, tx_data); else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111; req_last = 4'b1111; tx_data_ready = 1'b1;
        for (int i = 0; i < N; i++) req_data[i*8 +: 8] = 8'hA0 + 8'(i);
        for (int k = 0; k < 5; k++) begin
            clk_step();
            @(negedge clk);
            n_checks++; if (grant_idx !== 2'(k % N) || tx_data !== 8'hA0 + 8'(k % N) || busy !== 1'b1)
                $display("FAIL rr_order_%0d: got g=%0d d=%0h b=%0h want g=%0d d=%0h b=1",
                         k, grant_idx, tx_data, busy, k % N, 8'hA0 + 8'(k % N)); else n_pass++;
            n_checks++; if (req_ready !== 4'(1 << (k % N)))
                $display("FAIL rr_ready_%0d: got %b want %b", k, req_ready, 4'(1 << (k % N))); else n_pass++;
            if (k == 4) break;
            clk_step();
            @(negedge clk);
            n_checks++; if (msg_count !== 16'(k + 1) || busy !== 1'b0)
                $display("FAIL rr_count_%0d: got m=%0d b=%0h want m=%0d b=0", k, msg_count, busy, k + 1); else n_pass++;
        end
        zero_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        req_valid = 4'b0100; req_data[23:16] = 8'h55; req_last = '0; tx_data_ready = 1'b1;
        clk_step();
        clk_step();
        req_valid = 4'b1111; req_last = 4'b1011; req_data[23:16] = 8'h66; tx_data_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clk_step();
            @(negedge clk);
            n_checks++; if (tx_data !== 8'h66 || tx_data_valid !== 1'b1 || req_ready !== 4'b0 || grant_idx !== 2'd2)
                $display("FAIL stall_%0d: got d=%0h v=%0h r=%b g=%0d want 66 1 0000 2",
                         i, tx_data, tx_data_valid, req_ready, grant_idx); else n_pass++;
        end
        tx_data_ready = 1'b1; req_last = 4'b1111;
        clk_step();
        @(negedge clk);
        n_checks++; if (msg_count !== 16'd1 || busy !== 1'b0)
            $display("FAIL stall_done: got m=%0d b=%0h want 1 0", msg_count, busy); else n_pass++;
        clk_step();
        @(negedge clk);
        n_checks++; if (grant_idx !== 2'd3) $display("FAIL stall_next: got %0d want 3", grant_idx); else n_pass++;
        zero_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0001; req_data[7:0] = 8'h10; req_last = 4'b0001; tx_data_ready = 1'b1;
        clk_step();
        clk_step();
        req_valid = 4'b0010; req_last = '0; req_data[15:8] = 8'h20;
        clk_step();
        @(negedge clk);
        n_checks++; if (grant_idx !== 2'd1) $display("FAIL rmid_grant: got %0d want 1", grant_idx); else n_pass++;
        clk_step();
        rst = 1'b1;
        clk_step();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || tx_data_valid !== 1'b0 || msg_count !== 16'd0)
            $display("FAIL rmid_reset: got b=%0h v=%0h m=%0d want 0 0 0", busy, tx_data_valid, msg_count); else n_pass++;
        rst = 1'b0; req_valid = 4'b0011;
        clk_step();
        @(negedge clk);
        n_checks++; if (grant_idx !== 2'd0) $display("FAIL rmid_favour0: got %0d want 0", grant_idx); else n_pass++;
        zero_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.r_msg_count = 16'hFFFF;
        clk_step();
        release dut.r_msg_count;
        m_msg = 16'hFFFF;
        @(negedge clk);
        n_checks++; if (msg_count !== 16'hFFFF) $display("FAIL wrap_pre: got %0h want ffff", msg_count); else n_pass++;
        req_valid = 4'b1000; req_last = 4'b1000; req_data[31:24] = 8'h7E; tx_data_ready = 1'b1;
        clk_step();
        clk_step();
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (msg_count !== 16'h0000 || busy !== 1'b0)
            $display("FAIL wrap_post: got m=%0h b=%0h want 0 0", msg_count, busy); else n_pass++;
        zero_inputs();
    endtask

    task automatic test_three_req();
        do_reset();
        rv3 = 3'b111; rl3 = 3'b111; rd3 = {8'hC2, 8'hC1, 8'hC0}; rdy3 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            clk_step();
            @(negedge clk);
            n_checks++; if (gi3 !== 2'(k % 3) || td3 !== 8'hC0 + 8'(k % 3))
                $display("FAIL three_order_%0d: got g=%0d d=%0h want g=%0d", k, gi3, td3, k % 3); else n_pass++;
            clk_step();
        end
        @(negedge clk);
        n_checks++; if (mc3 !== 16'd5) $display("FAIL three_count: got %0d want 5", mc3); else n_pass++;
        zero_inputs();
    endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req_valid = 4'b0010; req_data[15:8] = 8'h31; req_last = '0; tx_data_ready = 1'b1;
        clk_step();
        clk_step();
        req_valid = 4'b0100; req_data[23:16] = 8'h32; req_last = 4'b0100;
        for (int i = 0; i < TO - 1; i++) clk_step();
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || grant_idx !== 2'd1)
            $display("FAIL to_hold: got b=%0h g=%0d want 1 1", busy, grant_idx); else n_pass++;
        clk_step();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || abort_count !== 8'd1 || msg_count !== 16'd0)
            $display("FAIL to_release: got b=%0h a=%0d m=%0d want 0 1 0", busy, abort_count, msg_count); else n_pass++;
        clk_step();
        @(negedge clk);
        n_checks++; if (grant_idx !== 2'd2 || tx_data !== 8'h32)
            $display("FAIL to_next: got g=%0d d=%0h want 2 32", grant_idx, tx_data); else n_pass++;
        zero_inputs();
    endtask
`endif

    task automatic test_random();
        logic       ev;
        logic [7:0] ed;
        logic [3:0] er;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 9) < 8);
                req_last[i]  = ($urandom_range(0, 3) == 0);
                req_data[i*8 +: 8] = 8'($urandom);
            end
            tx_data_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ev = m_busy ? req_valid[m_gnt] : 1'b0;
            ed = m_busy ? req_data[m_gnt*8 +: 8] : 8'h00;
            er = (m_busy && tx_data_ready) ? 4'(1 << m_gnt) : 4'b0;
            n_checks++; if (tx_data_valid !== ev || tx_data !== ed)
                $display("FAIL rnd_tx_%0d: got v=%0h d=%0h want v=%0h d=%0h", c, tx_data_valid, tx_data, ev, ed); else n_pass++;
            n_checks++; if (req_ready !== er) $display("FAIL rnd_ready_%0d: got %b want %b", c, req_ready, er); else n_pass++;
            n_checks++; if (busy !== m_busy || grant_idx !== 2'(m_gnt))
                $display("FAIL rnd_state_%0d: got b=%0h g=%0d want b=%0h g=%0d", c, busy, grant_idx, m_busy, m_gnt); else n_pass++;
            n_checks++; if (msg_count !== m_msg) $display("FAIL rnd_msg_%0d: got %0d want %0d", c, msg_count, m_msg); else n_pass++;
`ifdef UART_TX_ARB_TIMEOUT_EN
            n_checks++; if (abort_count !== m_abort)
                $display("FAIL rnd_abort_%0d: got %0d want %0d", c, abort_count, m_abort); else n_pass++;
`endif
            clk_step();
        end
        rst = 1'b0;
        zero_inputs();
    endtask

    initial begin
        test_reset();
        test_single_msg();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_three_req();
`ifdef UART_TX_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
